// File: rtl/wb_imem_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// wb_imem_prefetch_pkg
// Shared definitions for the instruction-fetch line buffer:
//   pf_state_e     - refill controller states
//   LINEWORDS_DEF  - default words per line buffer
//   ADRW_DEF       - default word-address width (byte address bits [23:2])
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package wb_imem_prefetch_pkg;

    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_FILL = 2'd1,
        PF_GAP  = 2'd2,
        PF_RESP = 2'd3
    } pf_state_e;

    localparam int LINEWORDS_DEF = 4;
    localparam int ADRW_DEF      = 22;

endpackage

// File: rtl/wb_imem_prefetch.sv
// ---------------------------------------------------------------------------
// wb_imem_prefetch
// Single-line instruction prefetch buffer between a CPU fetch port and a
// slow (QSPI) memory controller. A hit answers in one cycle; a miss refills
// the whole line, word by word, with one idle cycle between controller reads.
//
// Ports
//   clk_i    : clock, all state on rising edge
//   rst_in   : synchronous active-low reset
//   s_stb_i  : CPU fetch request, held until s_ack_o
//   s_adr_i  : CPU fetch word address (ADRW bits)
//   s_dat_o  : fetched instruction word, valid with s_ack_o
//   s_ack_o  : one-cycle fetch acknowledge
//   m_stb_o  : read strobe to the memory controller
//   m_adr_o  : word address of the current refill read
//   m_dat_i  : read data from the memory controller
//   m_ack_i  : read acknowledge, honoured only while m_stb_o is high
//   inval_i  : invalidate the buffered line
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_imem_prefetch
    import wb_imem_prefetch_pkg::*;
#(
    parameter int LINEWORDS = LINEWORDS_DEF,
    parameter int ADRW      = ADRW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_in,
    input  logic            s_stb_i,
    input  logic [ADRW-1:0] s_adr_i,
    output logic [31:0]     s_dat_o,
    output logic            s_ack_o,
    output logic            m_stb_o,
    output logic [ADRW-1:0] m_adr_o,
    input  logic [31:0]     m_dat_i,
    input  logic            m_ack_i,
    input  logic            inval_i
);

    localparam int OFFW = $clog2(LINEWORDS);
    localparam int TAGW = ADRW - OFFW;

    pf_state_e       state_q, state_d;
    logic            valid_q, valid_d;
    logic            pend_q, pend_d;
    logic [OFFW-1:0] cnt_q, cnt_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [ADRW-1:0] m_adr_q, m_adr_d;
    logic [31:0]     s_dat_q, s_dat_d;
    logic [31:0]     line_q [LINEWORDS];

    logic [TAGW-1:0] req_tag;
    logic [OFFW-1:0] req_off;
    logic            hit;
    logic            last_word;
    logic            wr_en;

    assign req_tag   = s_adr_i[ADRW-1:OFFW];
    assign req_off   = s_adr_i[OFFW-1:0];
    // A same-cycle invalidate must never be answered from stale data.
    assign hit       = valid_q & (tag_q == req_tag) & ~inval_i;
    assign last_word = (cnt_q == {OFFW{1'b1}});
    assign wr_en     = (state_q == PF_FILL) & m_ack_i;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        m_adr_d = m_adr_q;
        s_dat_d = s_dat_q;
        case (state_q)
            PF_IDLE: begin
                if (inval_i) valid_d = 1'b0;
                if (s_stb_i) begin
                    if (hit) begin
                        s_dat_d = line_q[req_off];
                        state_d = PF_RESP;
                    end else begin
                        m_adr_d = {req_tag, {OFFW{1'b0}}};
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = PF_FILL;
                    end
                end
            end
            PF_FILL: begin
                if (inval_i) pend_d = 1'b1;
                if (m_ack_i) begin
                    // The address may roll past the top line; the tag is kept
                    // separately so that roll-over is harmless.
                    m_adr_d = m_adr_q + ADRW'(1);
                    if (last_word) begin
                        tag_d   = req_tag;
                        valid_d = ~(pend_q | inval_i);
                        pend_d  = 1'b0;
                        // The last word is not in the array until this edge.
                        s_dat_d = (req_off == cnt_q) ? m_dat_i : line_q[req_off];
                        state_d = PF_RESP;
                    end else begin
                        cnt_d   = cnt_q + OFFW'(1);
                        state_d = PF_GAP;
                    end
                end
            end
            PF_GAP: begin
                if (inval_i) pend_d = 1'b1;
                state_d = PF_FILL;
            end
            PF_RESP: begin
                if (inval_i) valid_d = 1'b0;
                state_d = PF_IDLE;
            end
            default: state_d = PF_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q <= PF_IDLE;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            m_adr_q <= '0;
            s_dat_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            m_adr_q <= m_adr_d;
            s_dat_q <= s_dat_d;
        end
    end

    // Line storage and tag carry no reset; valid_q guards them.
    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
        if (wr_en) line_q[cnt_q] <= m_dat_i;
    end

    assign m_stb_o = (state_q == PF_FILL);
    assign s_ack_o = (state_q == PF_RESP);
    assign s_dat_o = s_dat_q;
    assign m_adr_o = m_adr_q;

endmodule

// File: doc/wb_imem_prefetch.md
WB_IMEM_PREFETCH -- requirements
Module: wb_imem_prefetch

Interface
REQ-001 Parameter LINEWORDS, default 4, words per line buffer; power of two, 2..16.
REQ-002 Parameter ADRW, default 22, word-address width (byte address bits [23:2]).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_in  in  1  reset; synchronous and active-low.
REQ-005 s_stb_i  in  1  CPU instruction-fetch request; held until s_ack_o.
REQ-006 s_adr_i  in  ADRW  CPU fetch word address; stable while s_stb_i high.
REQ-007 s_dat_o  out  32  fetched instruction word; valid when s_ack_o high.
REQ-008 s_ack_o  out  1  one-cycle fetch acknowledge.
REQ-009 m_stb_o  out  1  read request to the QSPI memory controller.
REQ-010 m_adr_o  out  ADRW  word address of the current refill read.
REQ-011 m_dat_i  in  32  read data from the memory controller.
REQ-012 m_ack_i  in  1  memory read acknowledge; only honoured while m_stb_o high.
REQ-013 inval_i  in  1  invalidate the line, e.g. on a data-side write to the memory region.

Function
REQ-014 Storage: LINEWORDS x 32-bit data words, one tag (ADRW-log2(LINEWORDS) bits), one valid bit.
REQ-015 Hit condition: valid & tag == s_adr_i[ADRW-1:log2(LINEWORDS)] & ~inval_i.
REQ-016 FSM states: IDLE, FILL, GAP, RESP.
REQ-017 IDLE, s_stb_i & hit -> RESP; s_dat_o <= word[offset].
REQ-018 IDLE, s_stb_i & miss -> FILL; m_adr_o <= line base (offset bits zero); word counter <= 0; valid <= 0.
REQ-019 FILL: m_stb_o=1; on m_ack_i, word[cnt] <= m_dat_i and m_adr_o increments.
REQ-020 FILL, m_ack_i with cnt < LINEWORDS-1 -> GAP and cnt increments.
REQ-021 FILL, m_ack_i with cnt == LINEWORDS-1 -> RESP.
REQ-022 Leaving FILL for RESP: tag updates; s_dat_o <= requested word, taken from m_dat_i when offset == LINEWORDS-1.
REQ-023 Leaving FILL for RESP: valid <= 1 unless an invalidate is pending.
REQ-024 GAP: m_stb_o=0 for exactly one cycle -> FILL; no back-to-back strobes to the controller.
REQ-025 RESP: s_ack_o=1 for exactly one cycle -> IDLE; hit latency is one cycle (stb sampled at edge n, ack high in cycle n+1).
REQ-026 Miss latency: 1 + sum of controller ack latencies + (LINEWORDS-1) GAP cycles + 1.
REQ-027 The refill always runs to completion; the line is never partially valid.
REQ-028 inval_i in IDLE or RESP clears valid on the next edge.
REQ-029 inval_i during FILL/GAP sets pend_inval; at fill end valid stays 0, the requested word is still returned, then pend_inval clears.
REQ-030 inval_i coincident with an IDLE request forces the miss path.
REQ-031 Line wrap: the top line (all tag bits 1) fills up to address 2^ADRW-1 with no counter overflow into the tag.
REQ-032 m_stb_o is never high in IDLE, GAP or RESP.
REQ-033 s_ack_o is never high outside RESP.

Reset
REQ-034 On rst_in=0 at an edge: FSM=IDLE, valid=0, pend_inval=0, cnt=0.
REQ-035 On rst_in=0 at an edge: m_stb_o=0, s_ack_o=0, s_dat_o=0, m_adr_o=0.
REQ-036 Data array and tag are not reset.
REQ-037 Reset mid-FILL abandons the refill at once; m_stb_o is low in the first cycle after reset.

Structure
REQ-038 Shared package holds the FSM state enum (pf_state_e) and LINEWORDS_DEF/ADRW_DEF constants.
REQ-039 Single module with no sub-module; the data array is a flop array indexed by offset.

Verification
REQ-040 Cold fetch at word adr 0x000010, controller ack after 3 cycles per read -> m_adr_o 0x10,0x11,0x12,0x13; each strobe followed by one low cycle; s_ack_o with s_dat_o=mem[0x10] at cycle 16.
REQ-041 Fetch 0x000012 right after REQ-040 -> no m_stb_o; s_ack_o one cycle after stb; s_dat_o=mem[0x12].
REQ-042 Fetch 0x000014 -> miss; refill 0x14..0x17; following fetch of 0x000011 misses again.
REQ-043 inval_i pulsed during 2nd refill word of 0x000020 -> requested word returned correctly; immediate re-fetch of 0x000020 triggers a full refill.
REQ-044 rst_in low for one cycle during 3rd refill word -> m_stb_o=0 next cycle; re-fetch of the same address performs a full 4-word refill.
REQ-045 Fetch 0x3FFFFF -> refill 0x3FFFFC..0x3FFFFF with no wrap into the tag; s_dat_o=mem[0x3FFFFF].
